input_handshake_ctrl: RTL and testbench
=======================================

INPUT_HANDSHAKE_CTRL -- requirements
Module: input_handshake_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a key press or release (legal range 1..65535).
REQ-002 SHALL have parameter DATA_W, default 15: switch and bus width.
REQ-003 SHALL have port clock  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high.
REQ-005 SHALL have port sw_in  input  DATA_W: raw board switches.
REQ-006 SHALL have port key_n  input  1: raw OK pushbutton, active-low, bouncing, asynchronous.
REQ-007 SHALL have port io_read  input  1: one-cycle strobe from the processor input instruction consuming bus_in.
REQ-008 SHALL have port bus_in  output  DATA_W: latched switch word presented to the processor.
REQ-009 SHALL have port ok  output  1: data-valid level to the processor.
REQ-010 SHALL have port overrun  output  1: sticky flag, press accepted while ok=1.

Function
REQ-011 SHALL pass key_n and sw_in each through a 2-flop synchronizer before any use.
REQ-012 SHALL run key FSM IDLE -> PRESS_DB -> PRESSED -> RELEASE_DB -> IDLE with a 16-bit stability counter.
REQ-013 IDLE: synchronized key low -> PRESS_DB with counter=1; else stay.
REQ-014 PRESS_DB: key high (bounce) -> IDLE with counter=0; key low and counter=DEBOUNCE_CYCLES -> PRESSED (accept event); else counter+1.
REQ-015 PRESSED: key high -> RELEASE_DB with counter=1; no further accept events while held.
REQ-016 RELEASE_DB: key low -> PRESSED with counter=0; key high and counter=DEBOUNCE_CYCLES -> IDLE; else counter+1.
REQ-017 Accept event with ok=0: SHALL load bus_in from the synchronized sw_in and set ok=1 on the same edge; latency from key_n fall (clean) to ok rise = DEBOUNCE_CYCLES+2 edges.
REQ-018 bus_in SHALL hold constant while ok=1 regardless of sw_in changes.
REQ-019 io_read with ok=1 SHALL clear ok on the next edge; io_read with ok=0 SHALL be ignored (no state change).
REQ-020 Accept event and io_read on the same edge: SHALL load new bus_in and keep ok=1 (capture wins); overrun unaffected.
REQ-021 Accept event with ok=1 and no io_read: handling per REQ-026/REQ-027; bus_in SHALL NOT change.
REQ-022 Counter SHALL saturate, never wrap; DEBOUNCE_CYCLES=1 accepts after one stable synchronized cycle.

Reset
REQ-023 reset asserted SHALL immediately force FSM=IDLE, counter=0, synchronizers to released (key=1, sw=0), bus_in=0, ok=0, overrun=0.
REQ-024 reset asserted mid-debounce or with ok=1 SHALL discard the pending press/data; after deassertion a key held low SHALL require full DEBOUNCE_CYCLES before acceptance.
REQ-025 Deassertion SHALL be synchronized externally; the block SHALL tolerate reset release on any edge.

Configuration
REQ-026 With INPUT_OVERRUN_EN defined: accept event while ok=1 and no same-edge io_read SHALL set overrun=1, held until reset.
REQ-027 Without INPUT_OVERRUN_EN: such presses SHALL be silently dropped and overrun SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: sw_in=0x1234, key_n low held -> ok=1, bus_in=0x1234 exactly 6 edges after key_n fall.
REQ-029 Bounce: key_n low 2 cycles, high 1, low held -> ok rises 6 edges after the final fall, not before.
REQ-030 Consume: ok=1, pulse io_read 1 cycle -> ok=0 next edge; change sw_in to 0x7FFF during ok=1 -> bus_in stays 0x1234.
REQ-031 Overrun: second press (sw_in=0x0005) after full release without io_read -> bus_in stays 0x1234, overrun=1 (macro on) / 0 (macro off).
REQ-032 Collision: io_read strobe on the accept edge of a new press (sw_in=0x0AAA) -> ok=1, bus_in=0x0AAA, overrun=0.
REQ-033 Reset mid-operation: reset pulse with ok=1 while PRESS_DB -> all outputs 0 immediately; key_n held low -> ok after 6 edges from deassertion.

Source files
------------

// File: rtl/input_handshake_ctrl.sv
// input_handshake_ctrl: debounced OK-key handshake that latches the switch word for the processor.
// Optional feature: define INPUT_OVERRUN_EN to flag presses accepted while data is still unread.
module input_handshake_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DATA_W          = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              key_n,
    input  logic              io_read,
    output logic [DATA_W-1:0] bus_in,
    output logic              ok,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

    logic              key_meta_d, key_meta_q, key_sync_d, key_sync_q;
    logic [DATA_W-1:0] sw_meta_d, sw_meta_q, sw_sync_d, sw_sync_q;
    state_t            state_d, state_q;
    logic [15:0]       cnt_d, cnt_q, cnt_inc;
    logic [DATA_W-1:0] bus_d, bus_q;
    logic              ok_d, ok_q, ovr_d, ovr_q;
    logic              stable_done, accept;

    // Two-flop synchronizers; reset value models a released key and all-zero switches
    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        sw_meta_d  = sw_in;
        sw_sync_d  = sw_meta_q;
    end

    // The counter holds the stable cycles already seen; the current cycle completes the window
    always_comb begin
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        stable_done = cnt_inc >= DB_LIMIT;
    end

    // Key debounce FSM: next state, stability counter and the one-cycle accept event
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_sync_q) begin
                    state_d = PRESS_DB;
                    cnt_d   = 16'd1;
                end
            end
            PRESS_DB: begin
                if (key_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (stable_done) begin
                    state_d = PRESSED;
                    cnt_d   = 16'd0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (key_sync_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = 16'd1;
                end
            end
            RELEASE_DB: begin
                if (!key_sync_q) begin
                    state_d = PRESSED;
                    cnt_d   = 16'd0;
                end else if (stable_done) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Handshake: a capture beats a same-edge read; an unread word is never overwritten
    always_comb begin
        bus_d = bus_q;
        ok_d  = ok_q;
        ovr_d = ovr_q;
        if (accept && (!ok_q || io_read)) begin
            bus_d = sw_sync_q;
            ok_d  = 1'b1;
        end else if (io_read && ok_q) begin
            ok_d = 1'b0;
        end
`ifdef INPUT_OVERRUN_EN
        if (accept && ok_q && !io_read) ovr_d = 1'b1;
`else
        ovr_d = 1'b0;
`endif
    end

    // State registers with asynchronous reset to the idle, released, empty condition
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            bus_q      <= '0;
            ok_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            ok_q       <= ok_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus_in  = bus_q;
    assign ok      = ok_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_input_handshake_ctrl.sv
// tb_input_handshake_ctrl: directed and randomized checks of the input handshake against a transaction-level model.
module tb_input_handshake_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] sw_in;
    logic        key_n;
    logic        io_read;
    logic [14:0] bus_in;
    logic        ok;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [14:0] m_bus;
    logic        m_ok;
    logic        m_ovr;

    input_handshake_ctrl #(.DEBOUNCE_CYCLES(4), .DATA_W(15)) dut (
        .clock(clock), .reset(reset), .sw_in(sw_in), .key_n(key_n),
        .io_read(io_read), .bus_in(bus_in), .ok(ok), .overrun(overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        check({tag, ".ok"}, 32'(ok), 32'(m_ok));
        check({tag, ".bus"}, 32'(bus_in), 32'(m_bus));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Model of one accepted press: empty slot or same-edge read captures, otherwise drop/flag
    task automatic model_accept(input logic [14:0] sw, input bit rd);
        if (!m_ok || rd) begin
            m_bus = sw;
            m_ok  = 1'b1;
        end else begin
`ifdef INPUT_OVERRUN_EN
            m_ovr = 1'b1;
`endif
        end
    endtask

    task automatic model_reset();
        m_bus = '0;
        m_ok  = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Clean press: outputs frozen for 5 edges after the fall, accept lands on edge 6
    task automatic press(input logic [14:0] sw, input bit collide);
        logic        p_ok;
        logic [14:0] p_bus;
        sw_in = sw;
        repeat (3) tick();
        p_ok  = m_ok;
        p_bus = m_bus;
        key_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("press.early_ok", 32'(ok), 32'(p_ok));
            check("press.early_bus", 32'(bus_in), 32'(p_bus));
        end
        io_read = collide;
        tick();
        io_read = 1'b0;
        model_accept(sw, collide);
        chk_all("press.accept");
        key_n = 1'b1;
        repeat (10) tick();
        chk_all("press.released");
    endtask

    task automatic consume();
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
        m_ok = 1'b0;
        chk_all("consume");
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        chk_all("reset.immediate");
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        key_n   = 1'b1;
        sw_in   = '0;
        io_read = 1'b0;
        model_reset();
        repeat (2) tick();
        chk_all("reset.state");
        reset = 1'b0;
        tick();

        io_read = 1'b1;
        tick();
        io_read = 1'b0;
        chk_all("idle_read_ignored");

        press(15'h1234, 1'b0);
        sw_in = 15'h7FFF;
        repeat (4) tick();
        chk_all("hold_bus");
        consume();

        sw_in = 15'h1234;
        repeat (3) tick();
        key_n = 1'b0;
        repeat (2) tick();
        key_n = 1'b1;
        tick();
        key_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("bounce.early_ok", 32'(ok), 32'd0);
        end
        tick();
        model_accept(15'h1234, 1'b0);
        chk_all("bounce.accept");
        key_n = 1'b1;
        repeat (10) tick();

        press(15'h0AAA, 1'b1);
        consume();
        press(15'h1234, 1'b0);
        press(15'h0005, 1'b0);
        check("overrun.bus", 32'(bus_in), 32'h1234);

        sw_in = 15'h0321;
        repeat (3) tick();
        key_n = 1'b0;
        repeat (3) tick();
        async_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("post_reset.early_ok", 32'(ok), 32'd0);
        end
        tick();
        model_accept(15'h0321, 1'b0);
        chk_all("post_reset.accept");
        key_n = 1'b1;
        repeat (10) tick();

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0: press(15'($urandom_range(0, 32767)), 1'b0);
                1: press(15'($urandom_range(0, 32767)), 1'b1);
                2: consume();
                3: begin
                    sw_in = 15'($urandom_range(0, 32767));
                    repeat (3) tick();
                    chk_all("rand.sw_change");
                end
                default: async_reset();
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
